image_ram_arbiter: RTL and testbench
====================================

IMAGE_RAM_ARBITER -- requirements
Module: image_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel word width.
REQ-002 Parameter ADDRESS_WIDTH, default 17: image RAM address width (320*240 pixels).
REQ-003 Parameter MAX_WAIT, default 15: starvation limit in cycles; legal range 1..255.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req1, req2  in  1 each  access request from requester 1 (decoder) and requester 2 (filter).
REQ-007 we1, we2  in  1 each  1 = write, 0 = read; sampled only during a granted access.
REQ-008 address1, address2  in  ADDRESS_WIDTH each  access address.
REQ-009 wdata1, wdata2  in  DATA_WIDTH each  write data.
REQ-010 gnt1, gnt2  out  1 each  registered grant; never both 1.
REQ-011 rdata1, rdata2  out  DATA_WIDTH each  read data, both driven from ram_rdata.
REQ-012 rvalid1, rvalid2  out  1 each  read data valid strobe.
REQ-013 ram_CE, ram_WE  out  1 each  RAM chip enable and write enable.
REQ-014 ram_address  out  ADDRESS_WIDTH  RAM address.
REQ-015 ram_wdata  out  DATA_WIDTH  RAM write data.
REQ-016 ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read with CE=1.
REQ-017 busy  out  1  1 whenever the state is not IDLE.

Function
REQ-018 FSM states: IDLE, OWN1, OWN2; gnt1 = (state==OWN1), gnt2 = (state==OWN2).
REQ-019 Access cycle: gntX=1 and reqX=1. In such a cycle the outputs SHALL be combinational from requester X: ram_CE=1, ram_WE=weX, ram_address=addressX, ram_wdata=wdataX.
REQ-020 Outside an access cycle, ram_CE=0, ram_WE=0, ram_address=0 and ram_wdata=0.
REQ-021 IDLE transitions: req1 -> OWN1; else req2 -> OWN2; else stay. Requester 1 wins simultaneous requests from IDLE.
REQ-022 OWNX transitions, other requester Y:
- reqX=0 and reqY=1 -> OWNY.
- reqX=0 and reqY=0 -> IDLE.
- reqX=1, reqY=1 and waitY==MAX_WAIT -> OWNY (forced handover).
- otherwise stay.
REQ-023 Grant latency: a request raised in cycle N from IDLE SHALL see gnt in cycle N+1. The grant is held for back-to-back bursts while req stays high.
REQ-024 Wait counters:
- Width clog2(MAX_WAIT+1).
- waitX increments in each cycle with reqX=1 and gntX=0, saturating at MAX_WAIT.
- waitX clears in any cycle with gntX=1 or reqX=0.
REQ-025 Forced handover SHALL occur after the access in the cycle where waitY reaches MAX_WAIT. The displaced requester keeps its request and is regranted under the same rules, so neither requester waits more than MAX_WAIT+1 cycles.
REQ-026 rvalidX SHALL be registered: it is 1 in cycle N+1 exactly when cycle N was a read access by X, otherwise 0.
REQ-027 Handover does not suppress rvalid: a read in the last owned cycle still produces rvalidX in the following cycle.
REQ-028 A requester dropping req while granted: that cycle is not an access. The transition per REQ-022 takes effect at the next edge.
REQ-029 Writes produce no rvalid. Write data is committed in the access cycle.

Reset
REQ-030 While rst=0, asynchronously:
- state = IDLE.
- gnt1 = gnt2 = 0, rvalid1 = rvalid2 = 0, busy = 0.
- wait counters = 0.
- ram_CE = ram_WE = 0, ram_address = 0, ram_wdata = 0.
REQ-031 Reset asserted mid-burst SHALL abort immediately, with no rvalid for an in-flight read. After rst returns to 1, arbitration restarts from IDLE at the next edge.

Verification
REQ-032 Single read: req1=1, we1=0, address1=0x00100 from IDLE -> gnt1 at N+1, ram_CE=1 with address 0x00100 at N+1, rvalid1=1 at N+2, rdata1 = RAM content.
REQ-033 Tie: req1 and req2 rise together -> gnt1 first. After req1 drops, gnt2 follows one cycle later. gnt1 and gnt2 are never simultaneously 1.
REQ-034 Starvation: req1 held for 40 cycles, req2 raised at cycle 2 with MAX_WAIT=15 -> gnt2 rises within 17 cycles of req2. gnt1 returns after req2 drops or wait1 reaches 15.
REQ-035 Write burst: req2=1, we2=1, addresses 0..7 -> 8 RAM writes with ram_WE=1 in consecutive cycles and no rvalid2.
REQ-036 Reset during read: rst=0 in the cycle after a granted read -> rvalid1=0, gnt1=0 and ram_CE=0 immediately. busy=0 until a new request arrives.
REQ-037 Idle release: owner drops req with no other request -> one non-access cycle in OWNX, then IDLE with busy=0.

Source files
------------

// File: rtl/image_ram_arbiter.sv
// image_ram_arbiter: two-requester image RAM arbiter with starvation-bounded handover
//   clk                  : single clock, rising edge
//   rst                  : asynchronous active-low reset
//   req1/req2            : access requests (1 = decoder, 2 = filter)
//   we1/we2              : 1 = write, 0 = read; used only during a granted access
//   address1/address2    : access addresses
//   wdata1/wdata2        : write data
//   gnt1/gnt2            : registered grants, mutually exclusive
//   rdata1/rdata2        : read data, both taken from ram_rdata
//   rvalid1/rvalid2      : registered read-valid strobes, one cycle after a read access
//   ram_CE/ram_WE        : RAM chip enable / write enable
//   ram_address          : RAM address
//   ram_wdata            : RAM write data
//   ram_rdata            : RAM read data, valid one cycle after a read
//   busy                 : 1 whenever a requester owns the RAM
module image_ram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 17,
    parameter int MAX_WAIT      = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req1,
    input  logic                     req2,
    input  logic                     we1,
    input  logic                     we2,
    input  logic [ADDRESS_WIDTH-1:0] address1,
    input  logic [ADDRESS_WIDTH-1:0] address2,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    input  logic [DATA_WIDTH-1:0]    wdata2,
    output logic                     gnt1,
    output logic                     gnt2,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic [DATA_WIDTH-1:0]    rdata2,
    output logic                     rvalid1,
    output logic                     rvalid2,
    output logic                     ram_CE,
    output logic                     ram_WE,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     busy
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

    state_t          state, state_nx;
    logic [WW-1:0]   wait1, wait2;
    logic            acc1, acc2;

    assign gnt1 = (state == OWN1);
    assign gnt2 = (state == OWN2);
    assign busy = (state != IDLE);
    assign acc1 = gnt1 && req1;
    assign acc2 = gnt2 && req2;

    assign ram_CE      = acc1 || acc2;
    assign ram_WE      = acc1 ? we1 : acc2 ? we2 : 1'b0;
    assign ram_address = acc1 ? address1 : acc2 ? address2 : '0;
    assign ram_wdata   = acc1 ? wdata1 : acc2 ? wdata2 : '0;
    assign rdata1      = ram_rdata;
    assign rdata2      = ram_rdata;

    // The registered wait counter means the handover happens one edge after
    // the waiter's count hits MAX_WAIT, bounding its wait to MAX_WAIT+1 cycles.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req1 ? OWN1 : req2 ? OWN2 : IDLE;
            OWN1:    state_nx = !req1 ? (req2 ? OWN2 : IDLE) : (req2 && wait2 == WMAX) ? OWN2 : OWN1;
            OWN2:    state_nx = !req2 ? (req1 ? OWN1 : IDLE) : (req1 && wait1 == WMAX) ? OWN1 : OWN2;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wait1   <= '0;
            wait2   <= '0;
            rvalid1 <= 1'b0;
            rvalid2 <= 1'b0;
        end else begin
            state   <= state_nx;
            wait1   <= (gnt1 || !req1) ? '0 : (wait1 == WMAX) ? wait1 : wait1 + 1'b1;
            wait2   <= (gnt2 || !req2) ? '0 : (wait2 == WMAX) ? wait2 : wait2 + 1'b1;
            rvalid1 <= acc1 && !we1;
            rvalid2 <= acc2 && !we2;
        end
    end
endmodule

// File: tb/tb_image_ram_arbiter.sv
// tb_image_ram_arbiter: directed self-checking bench for image_ram_arbiter
module tb_image_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req1 = 0, req2 = 0, we1 = 0, we2 = 0;
    logic [16:0] address1 = '0, address2 = '0;
    logic [7:0]  wdata1 = '0, wdata2 = '0;
    logic        gnt1, gnt2, rvalid1, rvalid2, ram_CE, ram_WE, busy;
    logic [7:0]  rdata1, rdata2, ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [16:0] ram_address;
    logic [7:0]  mem [0:(1<<17)-1];
    int          passed = 0, total = 0;

    image_ram_arbiter dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2), .we1(we1), .we2(we2),
        .address1(address1), .address2(address2), .wdata1(wdata1), .wdata2(wdata2),
        .gnt1(gnt1), .gnt2(gnt2), .rdata1(rdata1), .rdata2(rdata2),
        .rvalid1(rvalid1), .rvalid2(rvalid2), .ram_CE(ram_CE), .ram_WE(ram_WE),
        .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_CE) begin
            if (ram_WE) mem[ram_address] <= ram_wdata;
            else ram_rdata <= mem[ram_address];
        end
    end

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({gnt1, gnt2, rvalid1, rvalid2, busy, ram_CE, ram_WE} !== 7'b0 || ram_address !== 17'h0 || ram_wdata !== 8'h0)
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b busy=%b ce=%b we=%b addr=%h wd=%h, want all 0",
                     gnt1, gnt2, rvalid1, rvalid2, busy, ram_CE, ram_WE, ram_address, ram_wdata);
        else passed++;
        adv;
        adv;
        rst = 1'b1;
        adv;
    endtask

    task automatic test_single_read;
        req1 = 1; we1 = 1; address1 = 17'h00100; wdata1 = 8'hA5;
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b0 || ram_CE !== 1'b0) $display("FAIL read_no_early_grant: gnt1=%b ce=%b want 0 0", gnt1, ram_CE);
        else passed++;
        adv;
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b1 || ram_CE !== 1'b1 || ram_WE !== 1'b1 || ram_address !== 17'h00100 || ram_wdata !== 8'hA5)
            $display("FAIL preload_write: gnt1=%b ce=%b we=%b addr=%h wd=%h want 1 1 1 00100 a5", gnt1, ram_CE, ram_WE, ram_address, ram_wdata);
        else passed++;
        adv;
        we1 = 0;
        @(negedge clk);
        total++;
        if (rvalid1 !== 1'b0 || ram_CE !== 1'b1 || ram_WE !== 1'b0 || ram_address !== 17'h00100)
            $display("FAIL read_access: rvalid1=%b ce=%b we=%b addr=%h want 0 1 0 00100", rvalid1, ram_CE, ram_WE, ram_address);
        else passed++;
        adv;
        req1 = 0;
        @(negedge clk);
        total++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'hA5 || rvalid2 !== 1'b0)
            $display("FAIL read_data: rvalid1=%b rdata1=%h rvalid2=%b want 1 a5 0", rvalid1, rdata1, rvalid2);
        else passed++;
        total++;
        if (gnt1 !== 1'b1 || ram_CE !== 1'b0 || busy !== 1'b1)
            $display("FAIL release_cycle: gnt1=%b ce=%b busy=%b want 1 0 1", gnt1, ram_CE, busy);
        else passed++;
        adv;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt1 !== 1'b0 || rvalid1 !== 1'b0)
            $display("FAIL release_idle: busy=%b gnt1=%b rvalid1=%b want 0 0 0", busy, gnt1, rvalid1);
        else passed++;
    endtask

    task automatic test_tie;
        adv;
        req1 = 1; req2 = 1; we1 = 0; we2 = 0; address1 = 17'h11; address2 = 17'h22;
        adv;
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b1 || gnt2 !== 1'b0 || ram_address !== 17'h11)
            $display("FAIL tie_first: gnt1=%b gnt2=%b addr=%h want 1 0 00011", gnt1, gnt2, ram_address);
        else passed++;
        adv;
        req1 = 0;
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b1 || gnt2 !== 1'b0 || ram_CE !== 1'b0 || rvalid1 !== 1'b1)
            $display("FAIL tie_drop: gnt1=%b gnt2=%b ce=%b rvalid1=%b want 1 0 0 1", gnt1, gnt2, ram_CE, rvalid1);
        else passed++;
        adv;
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b0 || gnt2 !== 1'b1 || ram_address !== 17'h22 || rvalid1 !== 1'b0)
            $display("FAIL tie_second: gnt1=%b gnt2=%b addr=%h rvalid1=%b want 0 1 00022 0", gnt1, gnt2, ram_address, rvalid1);
        else passed++;
        adv;
        req2 = 0;
        @(negedge clk);
        total++;
        if (rvalid2 !== 1'b1) $display("FAIL tie_rvalid2: rvalid2=%b want 1", rvalid2);
        else passed++;
        adv;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rvalid2 !== 1'b0) $display("FAIL tie_idle: busy=%b rvalid2=%b want 0 0", busy, rvalid2);
        else passed++;
    endtask

    task automatic test_starvation;
        int  n;
        bit  both;
        adv;
        req1 = 1; we1 = 1; address1 = 17'h5; wdata1 = 8'h01;
        adv;
        adv;
        req2 = 1; we2 = 1; address2 = 17'h9; wdata2 = 8'h02;
        n = 0;
        both = 0;
        while (!gnt2 && n < 40) begin
            both |= gnt1 & gnt2;
            adv;
            n++;
        end
        total++;
        if (n !== 16) $display("FAIL starve_gnt2_delay: waited %0d cycles, want 16", n);
        else passed++;
        @(negedge clk);
        total++;
        if (ram_address !== 17'h9 || ram_WE !== 1'b1 || ram_wdata !== 8'h02)
            $display("FAIL starve_gnt2_access: addr=%h we=%b wd=%h want 00009 1 02", ram_address, ram_WE, ram_wdata);
        else passed++;
        n = 0;
        while (!gnt1 && n < 40) begin
            both |= gnt1 & gnt2;
            adv;
            n++;
        end
        total++;
        if (n !== 16) $display("FAIL starve_gnt1_return: waited %0d cycles, want 16", n);
        else passed++;
        total++;
        if (both !== 1'b0) $display("FAIL grant_exclusive: saw both grants high=%b want 0", both);
        else passed++;
        req1 = 0; req2 = 0;
        adv;
        adv;
    endtask

    task automatic test_back_to_back;
        bit bad = 0;
        req2 = 1; we2 = 1; address2 = 17'h0; wdata2 = 8'h30;
        adv;
        for (int i = 0; i < 8; i++) begin
            address2 = 17'(i); wdata2 = 8'h30 + 8'(i);
            @(negedge clk);
            if (ram_CE !== 1'b1 || ram_WE !== 1'b1 || ram_address !== 17'(i) || ram_wdata !== 8'h30 + 8'(i) || rvalid2 !== 1'b0) bad = 1;
            adv;
        end
        req2 = 0;
        @(negedge clk);
        total++;
        if (bad !== 1'b0) $display("FAIL burst_writes: bad beat seen=%b want 0", bad);
        else passed++;
        total++;
        if (mem[3] !== 8'h33 || mem[7] !== 8'h37 || rvalid2 !== 1'b0)
            $display("FAIL burst_commit: mem3=%h mem7=%h rvalid2=%b want 33 37 0", mem[3], mem[7], rvalid2);
        else passed++;
        adv;
        adv;
    endtask

    task automatic test_reset_during_read;
        req1 = 1; we1 = 0; address1 = 17'h00100;
        adv;
        adv;
        total++;
        if (rvalid1 !== 1'b1) $display("FAIL rst_pre_rvalid: rvalid1=%b want 1", rvalid1);
        else passed++;
        rst = 0;
        #1;
        total++;
        if (rvalid1 !== 1'b0 || gnt1 !== 1'b0 || ram_CE !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_async_abort: rvalid1=%b gnt1=%b ce=%b busy=%b want 0 0 0 0", rvalid1, gnt1, ram_CE, busy);
        else passed++;
        adv;
        rst = 1; req1 = 0;
        adv;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt1 !== 1'b0 || rvalid1 !== 1'b0)
            $display("FAIL rst_stays_idle: busy=%b gnt1=%b rvalid1=%b want 0 0 0", busy, gnt1, rvalid1);
        else passed++;
        adv;
        req1 = 1;
        adv;
        total++;
        if (gnt1 !== 1'b1 || busy !== 1'b1) $display("FAIL rst_regrant: gnt1=%b busy=%b want 1 1", gnt1, busy);
        else passed++;
        req1 = 0;
        adv;
        adv;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_tie;
        test_starvation;
        test_back_to_back;
        test_reset_during_read;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
